// File: rtl/fpu_pkg.sv
// Shared types and defaults for the FPU issue/hazard controller.
// Op classes, per-op latency lookup, and writeback-pipe depth.
package fpu_pkg;

   localparam int AW_D      = 5;
   localparam int ADD_LAT_D = 3;
   localparam int MUL_LAT_D = 4;
   localparam int DIV_LAT_D = 12;
   // The writeback pipe must hold the longest-latency op, which is the divider.
   localparam int DSIZE     = DIV_LAT_D;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_MUL = 2'd1,
      OP_DIV = 2'd2,
      OP_MOV = 2'd3
   } fpu_op_e;

   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_BUSY = 1'b1
   } div_state_e;

   typedef logic [AW_D-1:0] reg_addr_t;

   function automatic int op_lat(input fpu_op_e op, input int add_lat,
                                 input int mul_lat, input int div_lat);
      case (op)
         OP_ADD:  return add_lat;
         OP_MUL:  return mul_lat;
         OP_DIV:  return div_lat;
         default: return 1;
      endcase
   endfunction

endpackage

// File: rtl/fpu_wb_slot_pipe.sv
// Writeback slot pipe: one {valid, addr} entry per cycle of future writeback.
// Shifts toward slot 0 every cycle; slot 0 is the retiring result.
module fpu_wb_slot_pipe
   import fpu_pkg::*;
#(
   parameter int AW    = AW_D,
   parameter int DSIZE = fpu_pkg::DSIZE,
   localparam int LW   = $clog2(DSIZE + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [LW-1:0] wr_lat,
   input  logic [AW-1:0] wr_addr,
   input  logic [LW-1:0] q_lat,
   output logic          q_busy,
   output logic          out_v,
   output logic [AW-1:0] out_addr
);

   logic [DSIZE-1:0] slot_v;
   logic [AW-1:0]    slot_a [DSIZE];
   logic [LW-1:0]    wr_idx;

   assign wr_idx = wr_lat - LW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_v <= '0;
         for (int i = 0; i < DSIZE; i++) slot_a[i] <= '0;
      end else if (flush) begin
         slot_v <= '0;
         for (int i = 0; i < DSIZE; i++) slot_a[i] <= '0;
      end else begin
         for (int i = 0; i < DSIZE - 1; i++) begin
            slot_v[i] <= slot_v[i+1];
            slot_a[i] <= slot_a[i+1];
         end
         slot_v[DSIZE-1] <= 1'b0;
         slot_a[DSIZE-1] <= '0;
         if (wr_en) begin
            slot_v[wr_idx] <= 1'b1;
            slot_a[wr_idx] <= wr_addr;
         end
      end
   end

   // Slot L-1 after this cycle's shift is today's slot L; a latency equal to
   // DSIZE lands in the freshly emptied top slot and can never collide.
   always_comb begin
      q_busy = 1'b0;
      for (int i = 0; i < DSIZE; i++)
         if (q_lat == LW'(i)) q_busy = slot_v[i];
   end

   assign out_v    = slot_v[0];
   assign out_addr = slot_a[0];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue/hazard controller: RAW/WAW/port/divider stall decisions, pending-dest
// scoreboard, divider occupancy FSM and writeback-bus forward selects.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int AW      = AW_D,
   parameter int ADD_LAT = ADD_LAT_D,
   parameter int MUL_LAT = MUL_LAT_D,
   parameter int DIV_LAT = DIV_LAT_D
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          issue_valid,
   input  logic [1:0]    issue_op,
   input  logic [AW-1:0] issue_rl,
   input  logic [AW-1:0] issue_rr,
   input  logic [AW-1:0] issue_rd,
   output logic          issue_ready,
   output logic          fwd_l_sel,
   output logic          fwd_r_sel,
   output logic          wb_valid,
   output logic [AW-1:0] wb_addr,
   output logic          div_busy
);

   localparam int NSLOT = DIV_LAT;
   localparam int LW    = $clog2(NSLOT + 1);
   localparam int CW    = $clog2(DIV_LAT + 1);

   fpu_op_e          op;
   logic [LW-1:0]    lat;
   logic             port_busy;
   logic             accept, wr_en;
   logic             raw_l, raw_r, waw, port_hz, div_hz;
   logic [(2**AW)-1:0] pend, pend_nxt;
   div_state_e       div_state, div_state_nxt;
   logic [CW-1:0]    div_cnt, div_cnt_nxt;

   assign op  = fpu_op_e'(issue_op);
   assign lat = LW'(op_lat(op, ADD_LAT, MUL_LAT, DIV_LAT));

   fpu_wb_slot_pipe #(.AW(AW), .DSIZE(NSLOT)) u_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .wr_en    (wr_en),
      .wr_lat   (lat),
      .wr_addr  (issue_rd),
      .q_lat    (lat),
      .q_busy   (port_busy),
      .out_v    (wb_valid),
      .out_addr (wb_addr)
   );

   assign fwd_l_sel = wb_valid && (wb_addr != '0) && (wb_addr == issue_rl);
   assign fwd_r_sel = wb_valid && (wb_addr != '0) && (wb_addr == issue_rr);

   assign raw_l   = (issue_rl != '0) && pend[issue_rl] && !fwd_l_sel;
   assign raw_r   = (issue_rr != '0) && pend[issue_rr] && !fwd_r_sel;
   assign waw     = (issue_rd != '0) && pend[issue_rd] && !(wb_valid && wb_addr == issue_rd);
   assign port_hz = (issue_rd != '0) && port_busy;
   assign div_hz  = (op == OP_DIV) && div_busy;

   // Handshake: an op transfers on any cycle with issue_valid && issue_ready;
   // issue_ready is computed without looking at issue_valid, so decode may hold
   // or change its op freely while stalled.
   assign issue_ready = !(raw_l || raw_r || waw || port_hz || div_hz || flush);
   assign accept      = issue_valid && issue_ready;
   assign wr_en       = accept && (issue_rd != '0);

   // Retiring clear first, then the new set, so a same-edge set on one reg wins.
   always_comb begin
      pend_nxt = pend;
      if (wb_valid) pend_nxt[wb_addr] = 1'b0;
      if (wr_en)    pend_nxt[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     pend <= '0;
      else if (flush) pend <= '0;
      else            pend <= pend_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_state <= DIV_IDLE;
         div_cnt   <= '0;
      end else if (flush) begin
         div_state <= DIV_IDLE;
         div_cnt   <= '0;
      end else begin
         div_state <= div_state_nxt;
         div_cnt   <= div_cnt_nxt;
      end
   end

   // The divider is released on the cycle its result retires, so a back-to-back
   // divide can be accepted exactly DIV_LAT cycles after the previous one.
   always_comb begin
      div_state_nxt = div_state;
      div_cnt_nxt   = div_cnt;
      case (div_state)
         DIV_IDLE: begin
            if (accept && (op == OP_DIV) && (DIV_LAT > 1)) begin
               div_state_nxt = DIV_BUSY;
               div_cnt_nxt   = CW'(DIV_LAT - 1);
            end
         end
         DIV_BUSY: begin
            div_cnt_nxt = div_cnt - CW'(1);
            if (div_cnt_nxt == '0) div_state_nxt = DIV_IDLE;
         end
         default: div_state_nxt = DIV_IDLE;
      endcase
   end

   assign div_busy = (div_state == DIV_BUSY);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: per-cycle stall/forward/busy checks plus a
// writeback scoreboard keyed by expected retire cycle.
module tb_fpu_issue_ctrl;

   localparam logic [1:0] T_ADD = 2'd0;
   localparam logic [1:0] T_MUL = 2'd1;
   localparam logic [1:0] T_DIV = 2'd2;
   localparam logic [1:0] T_MOV = 2'd3;

   logic       clk, rst_n, flush, issue_valid;
   logic [1:0] issue_op;
   logic [4:0] issue_rl, issue_rr, issue_rd;
   logic       issue_ready, fwd_l_sel, fwd_r_sel, wb_valid, div_busy;
   logic [4:0] wb_addr;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] cyc = '0;
   // Entry: {retire cycle[15:0], dest reg[4:0]}
   logic [20:0] exp_q[$];

   fpu_issue_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_op    (issue_op),
      .issue_rl    (issue_rl),
      .issue_rr    (issue_rr),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .fwd_l_sel   (fwd_l_sel),
      .fwd_r_sel   (fwd_r_sel),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .div_busy    (div_busy)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 16'd1;

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1);
   end

   function automatic logic [15:0] lat_of(input logic [1:0] op);
      case (op)
         2'd0:    return 16'd3;
         2'd1:    return 16'd4;
         2'd2:    return 16'd12;
         default: return 16'd1;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %0d, required %0d", name, cyc, act, exp);
      end
   endtask

   // Driver: present one op for one cycle and check the combinational response.
   task automatic cyc_op(input logic v, input logic [1:0] op, input logic [4:0] rl,
                         input logic [4:0] rr, input logic [4:0] rd, input logic fl,
                         input logic e_rdy, input logic e_fl, input logic e_fr,
                         input logic e_busy);
      issue_valid = v;
      issue_op    = op;
      issue_rl    = rl;
      issue_rr    = rr;
      issue_rd    = rd;
      flush       = fl;
      @(negedge clk);
      chk("issue_ready", int'(issue_ready), int'(e_rdy));
      chk("fwd_l_sel", int'(fwd_l_sel), int'(e_fl));
      chk("fwd_r_sel", int'(fwd_r_sel), int'(e_fr));
      chk("div_busy", int'(div_busy), int'(e_busy));
      if (v && e_rdy && !fl && rd != 5'd0) exp_q.push_back({cyc + lat_of(op), rd});
      if (fl) exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      issue_valid = 1'b0;
      issue_op    = T_ADD;
      issue_rl    = '0;
      issue_rr    = '0;
      issue_rd    = '0;
      flush       = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard monitor: every retirement must match an expected entry for this cycle.
   always @(negedge clk) begin
      int idx;
      if (rst_n) begin
         if (wb_valid) begin
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++)
               if (exp_q[i][20:5] == cyc) idx = i;
            n_vec++;
            if (idx < 0) begin
               n_err++;
               $display("FAIL wb_unexpected cyc=%0d: got wb_addr %0d, required no writeback", cyc, wb_addr);
            end else begin
               if (exp_q[idx][4:0] != wb_addr) begin
                  n_err++;
                  $display("FAIL wb_addr cyc=%0d: got %0d, required %0d", cyc, wb_addr, exp_q[idx][4:0]);
               end
               exp_q.delete(idx);
            end
         end
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i][20:5] < cyc) begin
               n_vec++;
               n_err++;
               $display("FAIL wb_missing cyc=%0d: got no writeback, required r%0d at cyc %0d",
                        cyc, exp_q[i][4:0], exp_q[i][20:5]);
               exp_q.delete(i);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_wb_valid", int'(wb_valid), 0);
      chk("rst_wb_addr", int'(wb_addr), 0);
      chk("rst_div_busy", int'(div_busy), 0);
      chk("rst_fwd_l", int'(fwd_l_sel), 0);
      chk("rst_fwd_r", int'(fwd_r_sel), 0);
      chk("rst_issue_ready", int'(issue_ready), 1);
      @(posedge clk);
      #1;

      // ADD r3 retires at +3; dependent ADD stalls two cycles then forwards
      cyc_op(1, T_ADD, 5'd1, 5'd2, 5'd3,  0, 1, 0, 0, 0);
      cyc_op(1, T_ADD, 5'd3, 5'd5, 5'd4,  0, 0, 0, 0, 0);
      cyc_op(1, T_ADD, 5'd3, 5'd5, 5'd4,  0, 0, 0, 0, 0);
      cyc_op(1, T_ADD, 5'd3, 5'd5, 5'd4,  0, 1, 1, 0, 0);
      cyc_op(1, T_ADD, 5'd3, 5'd3, 5'd0,  0, 1, 0, 0, 0);
      idle(3);

      // Divider structural hazard: second DIV waits until the cycle the first retires
      cyc_op(1, T_DIV, 5'd1, 5'd2, 5'd6,  0, 1, 0, 0, 0);
      for (int k = 1; k <= 11; k++)
         cyc_op(1, T_DIV, 5'd1, 5'd2, 5'd7, 0, 0, 0, 0, 1);
      cyc_op(1, T_DIV, 5'd1, 5'd2, 5'd7,  0, 1, 0, 0, 0);
      idle(13);

      // Writeback port conflict: MUL then ADD would both land on the same cycle
      cyc_op(1, T_MUL, 5'd1, 5'd2, 5'd8,  0, 1, 0, 0, 0);
      cyc_op(1, T_ADD, 5'd1, 5'd2, 5'd9,  0, 0, 0, 0, 0);
      cyc_op(1, T_ADD, 5'd1, 5'd2, 5'd9,  0, 1, 0, 0, 0);
      idle(4);

      // r0 handling, MOV latency 1, WAW stall and same-edge set-over-clear
      cyc_op(1, T_ADD, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 0);
      cyc_op(1, T_MOV, 5'd0, 5'd0, 5'd11, 0, 1, 0, 0, 0);
      cyc_op(1, T_ADD, 5'd11, 5'd0, 5'd12, 0, 1, 1, 0, 0);
      cyc_op(1, T_ADD, 5'd1, 5'd2, 5'd12, 0, 0, 0, 0, 0);
      cyc_op(1, T_ADD, 5'd1, 5'd2, 5'd12, 0, 0, 0, 0, 0);
      cyc_op(1, T_ADD, 5'd1, 5'd2, 5'd12, 0, 1, 0, 0, 0);
      cyc_op(1, T_ADD, 5'd12, 5'd0, 5'd13, 0, 0, 0, 0, 0);
      idle(3);

      // Flush kills the in-flight DIV; an op presented with flush is dropped
      cyc_op(1, T_DIV, 5'd1, 5'd2, 5'd6,  0, 1, 0, 0, 0);
      cyc_op(0, T_ADD, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 1);
      cyc_op(1, T_ADD, 5'd1, 5'd2, 5'd9,  1, 0, 0, 0, 1);
      cyc_op(1, T_DIV, 5'd6, 5'd9, 5'd7,  0, 1, 0, 0, 0);
      cyc_op(1, T_MOV, 5'd0, 5'd0, 5'd14, 0, 1, 0, 0, 1);

      // Async reset mid-DIV while a MOV result is on the writeback bus
      issue_valid = 1'b0;
      issue_op    = T_ADD;
      issue_rl    = 5'd14;
      issue_rr    = 5'd0;
      issue_rd    = 5'd0;
      flush       = 1'b0;
      #3;
      chk("pre_rst_wb_valid", int'(wb_valid), 1);
      chk("pre_rst_wb_addr", int'(wb_addr), 14);
      chk("pre_rst_div_busy", int'(div_busy), 1);
      chk("pre_rst_fwd_l", int'(fwd_l_sel), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_wb_valid", int'(wb_valid), 0);
      chk("arst_wb_addr", int'(wb_addr), 0);
      chk("arst_div_busy", int'(div_busy), 0);
      chk("arst_fwd_l", int'(fwd_l_sel), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);

      chk("exp_q_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
